bus_master_port: RTL and testbench
==================================

Name: bus_master_port

Overview:
- Master-side adapter between a parallel request interface and the bit-serial bus slave.
- Accepts one single-beat read or write request at a time.
- Serializes the request onto the serial valid/wren/address/data lines, then deserializes read data from the slave's validOut/DataOut.
- Returns a completion or timeout response. Burst transfers are out of scope: the burst line is driven 0.

Parameters:
- N, 8, data width in bits.
- ADN, 12, address length in bits; must be ≥ N.
- TIMEOUT, 64, cycles to wait in WAIT_RD for slave rvalid before flagging an error.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req  in  1  request strobe; sampled only when req_ready=1.
- req_wr  in  1  1=write, 0=read.
- req_addr  in  ADN  target address.
- req_wdata  in  N  write data.
- req_ready  out  1  1 when in IDLE and bus_ready=1.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  N  read data, valid with resp_valid on reads; 0 on writes.
- resp_err  out  1  timeout flag, valid with resp_valid.
- bus_valid  out  1  drives slave validIn.
- bus_wren  out  1  drives slave wren.
- bus_addr  out  1  drives slave Address, MSB first.
- bus_wdata  out  1  drives slave DataIn, MSB first.
- bus_burst  out  1  drives slave BurstEn; constant 0.
- bus_ready  in  1  slave ready.
- bus_rvalid  in  1  slave validOut.
- bus_rdata  in  1  slave DataOut.

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset: all outputs 0, state IDLE, all counters and shift registers 0. Reset mid-transfer aborts immediately; no resp_valid is generated.
- All outputs are registered.

State machine:
- IDLE
  - req && req_ready: latch addr/wdata/wr into shift registers, go to REQ.
  - Otherwise stay. req while not in IDLE is ignored; there is no queueing.
- REQ (1 cycle)
  - bus_valid=1, bus_wren=wr, bus_addr=0, bus_wdata=0. Go to ADDR.
- ADDR (exactly ADN cycles, counter 0..ADN-1)
  - bus_valid=1, bus_wren=wr, bus_addr = addr shift MSB, shifting left each cycle.
  - Write: in cycles ADN-N..ADN-1, bus_wdata = wdata shift MSB, shifting left. Otherwise bus_wdata=0.
  - After the last cycle: write goes to WCOMMIT; read goes to WAIT_RD.
- WCOMMIT (2 cycles)
  - bus_valid=0, bus_wren=0.
  - Then resp_valid=1 for 1 cycle, resp_err=0, resp_rdata=0. Return to IDLE.
- WAIT_RD
  - bus_valid=0.
  - First cycle with bus_rvalid=1 is the slave's load cycle: discard it, go to RDATA.
  - Timeout counter increments each cycle. If it reaches TIMEOUT: resp_valid=1, resp_err=1, resp_rdata=0, return to IDLE.
- RDATA
  - Each cycle with bus_rvalid=1: shift bus_rdata into the LSB of the rdata register, increment bit count.
  - Cycles with bus_rvalid=0 are ignored (stall), but the timeout counter continues to run.
  - After N bits: resp_valid=1, resp_rdata=register, resp_err=0, go to IDLE.
  - Timeout in RDATA behaves as in WAIT_RD.

Timing and counters:
- Write latency: 1+ADN+2 cycles from acceptance to resp_valid.
- Read latency: 1+ADN + slave delay + 1+N cycles.
- Timeout counter resets on entry to WAIT_RD and does not wrap; the width of the bit counter holds ADN.
- resp_valid is a single-cycle pulse in all cases; req_ready=0 during the resp_valid cycle.

Test Plan:
- Write addr=0xABC, data=0x5A:
  - bus_addr over the 12 ADDR cycles = 1,0,1,0,1,0,1,1,1,1,0,0.
  - bus_wdata over ADDR cycles 4..11 = 0,1,0,1,1,0,1,0; bus_wren=1 throughout.
  - resp_valid 15 cycles after acceptance; slave model memory[0xABC]=0x5A.
- Read addr=0x003 against slave model holding 0xA5:
  - bus_wren=0 in REQ/ADDR; the load cycle is discarded.
  - resp_rdata=0xA5, resp_err=0.
- Read with bus_rvalid never asserted, TIMEOUT=64 → resp_valid with resp_err=1 exactly 64 cycles after WAIT_RD entry.
- bus_ready=0 while req=1 → req_ready=0, no bus activity. Raise bus_ready → transfer starts the next cycle.
- req pulsed during ADDR of a prior write → ignored; only one resp_valid.
- Reset asserted in ADDR cycle 5 → next cycle all outputs 0, state IDLE, no resp_valid. A following read completes correctly.

Source files
------------

// File: rtl/bus_master_port.sv
// Master-side adapter: serializes one single-beat read/write request onto the bit-serial
// bus slave and deserializes the read data, returning a completion or timeout response.
module bus_master_port #(
    parameter int N       = 8,
    parameter int ADN     = 12,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req,
    input  logic           req_wr,
    input  logic [ADN-1:0] req_addr,
    input  logic [N-1:0]   req_wdata,
    output logic           req_ready,
    output logic           resp_valid,
    output logic [N-1:0]   resp_rdata,
    output logic           resp_err,
    output logic           bus_valid,
    output logic           bus_wren,
    output logic           bus_addr,
    output logic           bus_wdata,
    output logic           bus_burst,
    input  logic           bus_ready,
    input  logic           bus_rvalid,
    input  logic           bus_rdata
);

    localparam int CW = $clog2(ADN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADN - 1);
    localparam logic [CW-1:0] WSTART    = CW'(ADN - N);
    localparam logic [CW-1:0] BIT_LAST  = CW'(N - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        ADDR    = 3'd2,
        WCOMMIT = 3'd3,
        WAIT_RD = 3'd4,
        RDATA   = 3'd5
    } state_t;

    state_t         state_r;
    logic [ADN-1:0] addr_sh_r;
    logic [N-1:0]   wdata_sh_r;
    logic [N-2:0]   rdata_sh_r;
    logic           wr_r;
    logic [CW-1:0]  cnt_r;
    logic [TW-1:0]  tmo_r;

    logic [CW-1:0]  next_idx_s;
    logic           wdata_slot_s;
    logic [N-1:0]   rdata_next_s;

    // Index of the ADDR cycle presented after the coming edge, and the read-data shift result.
    always_comb begin
        next_idx_s = {CW{1'b0}};
        if (state_r == ADDR) begin
            next_idx_s = cnt_r + CW'(1'b1);
        end else begin
            next_idx_s = {CW{1'b0}};
        end
        wdata_slot_s = wr_r && (next_idx_s >= WSTART);
        rdata_next_s = {rdata_sh_r, bus_rdata};
    end

    // Control FSM; every bus and response output is registered here alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            addr_sh_r  <= {ADN{1'b0}};
            wdata_sh_r <= {N{1'b0}};
            rdata_sh_r <= {(N-1){1'b0}};
            wr_r       <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            tmo_r      <= {TW{1'b0}};
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= {N{1'b0}};
            resp_err   <= 1'b0;
            bus_valid  <= 1'b0;
            bus_wren   <= 1'b0;
            bus_addr   <= 1'b0;
            bus_wdata  <= 1'b0;
            bus_burst  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= {N{1'b0}};
            bus_burst  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req && req_ready) begin
                        addr_sh_r  <= req_addr;
                        wdata_sh_r <= req_wdata;
                        wr_r       <= req_wr;
                        req_ready  <= 1'b0;
                        bus_valid  <= 1'b1;
                        bus_wren   <= req_wr;
                        bus_addr   <= 1'b0;
                        bus_wdata  <= 1'b0;
                        state_r    <= REQ;
                    end else begin
                        req_ready <= bus_ready;
                    end
                end
                REQ, ADDR: begin
                    if (state_r == ADDR && cnt_r == ADDR_LAST) begin
                        bus_valid  <= 1'b0;
                        bus_wren   <= 1'b0;
                        bus_addr   <= 1'b0;
                        bus_wdata  <= 1'b0;
                        cnt_r      <= {CW{1'b0}};
                        tmo_r      <= {TW{1'b0}};
                        rdata_sh_r <= {(N-1){1'b0}};
                        state_r    <= wr_r ? WCOMMIT : WAIT_RD;
                    end else begin
                        cnt_r     <= next_idx_s;
                        bus_addr  <= addr_sh_r[ADN-1];
                        addr_sh_r <= addr_sh_r << 1;
                        if (wdata_slot_s) begin
                            bus_wdata  <= wdata_sh_r[N-1];
                            wdata_sh_r <= wdata_sh_r << 1;
                        end else begin
                            bus_wdata <= 1'b0;
                        end
                        state_r <= ADDR;
                    end
                end
                WCOMMIT: begin
                    if (cnt_r == CW'(1'b1)) begin
                        resp_valid <= 1'b1;
                        cnt_r      <= {CW{1'b0}};
                        state_r    <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1'b1);
                    end
                end
                WAIT_RD, RDATA: begin
                    // A final data bit landing on the timeout edge still counts as a completion.
                    if (state_r == RDATA && bus_rvalid && cnt_r == BIT_LAST) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_next_s;
                        rdata_sh_r <= {(N-1){1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        tmo_r      <= {TW{1'b0}};
                        state_r    <= IDLE;
                    end else if (tmo_r == TMO_LAST) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        rdata_sh_r <= {(N-1){1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        tmo_r      <= {TW{1'b0}};
                        state_r    <= IDLE;
                    end else begin
                        tmo_r <= tmo_r + TW'(1'b1);
                        if (bus_rvalid && state_r == WAIT_RD) begin
                            state_r <= RDATA;
                        end else if (bus_rvalid) begin
                            rdata_sh_r <= rdata_next_s[N-2:0];
                            cnt_r      <= cnt_r + CW'(1'b1);
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b0;
                    bus_valid <= 1'b0;
                    bus_wren  <= 1'b0;
                    bus_addr  <= 1'b0;
                    bus_wdata <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench: behavioural serial slave, response model from latency formulas, table + random + corner sequences.
module tb_bus_master_port;

    localparam int N       = 8;
    localparam int ADN     = 12;
    localparam int TIMEOUT = 64;

    logic           clk = 1'b0;
    logic           reset, req, req_wr, req_ready, resp_valid, resp_err;
    logic [ADN-1:0] req_addr;
    logic [N-1:0]   req_wdata, resp_rdata;
    logic           bus_valid, bus_wren, bus_addr, bus_wdata, bus_burst;
    logic           bus_ready, bus_rvalid, bus_rdata;
    logic [N+7:0]   outs_s;

    bus_master_port #(.N(N), .ADN(ADN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .bus_valid(bus_valid),
        .bus_wren(bus_wren), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_burst(bus_burst), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;
    assign outs_s = {req_ready, resp_valid, resp_rdata, resp_err, bus_valid, bus_wren,
                     bus_addr, bus_wdata, bus_burst};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Slave model state: memory, per-transfer read timing knobs, last decoded transfer.
    logic [N-1:0] smem    [0:4095];
    logic [N-1:0] ref_mem [0:4095];
    int           sl_delay = 0;
    logic [N-1:0] sl_stall = '0;
    bit           sl_mute  = 1'b0;
    logic [1:0]   sq [$];
    int           s_cnt, last_len, txn_cnt;
    logic [ADN:0] s_av, s_dv, s_wv, last_av, last_dv, last_wv;
    bit           burst_seen;

    initial begin
        s_cnt = 0; txn_cnt = 0; last_len = 0; burst_seen = 1'b0;
        s_av = '0; s_dv = '0; s_wv = '0; last_av = '0; last_dv = '0; last_wv = '0;
        bus_rvalid = 1'b0; bus_rdata = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_burst !== 1'b0) burst_seen = 1'b1;
            if (reset) begin
                s_cnt = 0; s_av = '0; s_dv = '0; s_wv = '0;
                sq.delete();
            end else if (bus_valid) begin
                s_av = {s_av[ADN-1:0], bus_addr};
                s_dv = {s_dv[ADN-1:0], bus_wdata};
                s_wv = {s_wv[ADN-1:0], bus_wren};
                s_cnt++;
            end else if (s_cnt != 0) begin
                last_av = s_av; last_dv = s_dv; last_wv = s_wv; last_len = s_cnt;
                txn_cnt++;
                if (s_wv[ADN]) begin
                    smem[s_av[ADN-1:0]] = s_dv[N-1:0];
                end else if (!sl_mute) begin
                    for (int i = 0; i < sl_delay; i++) sq.push_back(2'b00);
                    sq.push_back(2'b10);
                    for (int b = N - 1; b >= 0; b--) begin
                        if (sl_stall[b]) sq.push_back(2'b00);
                        sq.push_back({1'b1, smem[s_av[ADN-1:0]][b]});
                    end
                end
                s_cnt = 0; s_av = '0; s_dv = '0; s_wv = '0;
            end
            if (sq.size() > 0) {bus_rvalid, bus_rdata} = sq.pop_front();
            else {bus_rvalid, bus_rdata} = 2'b00;
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (req_ready && sq.size() == 0) return;
        end
        check("idle_wait", 32'(req_ready), 32'd1);
    endtask

    task automatic wait_resp(input int k0, output int lat, output logic [N-1:0] rd,
                             output logic er, output logic rr);
        lat = -1; rd = '0; er = 1'b0; rr = 1'b0;
        for (int k = k0; k < 300; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k; rd = resp_rdata; er = resp_err; rr = req_ready;
                return;
            end
        end
    endtask

    // One complete transaction; the expected latency comes from the published latency rules.
    task automatic run(input string nm, input bit wr, input logic [ADN-1:0] a,
                       input logic [N-1:0] d, input int dly, input logic [N-1:0] stl,
                       input bit mute, input logic [N-1:0] exp_rd, input bit exp_err);
        int lat, exp_lat;
        logic [N-1:0] rd;
        logic er, rr;
        sl_delay = dly; sl_stall = stl; sl_mute = mute;
        wait_idle();
        req = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        @(negedge clk);
        req = 1'b0;
        wait_resp(1, lat, rd, er, rr);
        if (wr) exp_lat = 1 + ADN + 2;
        else if (exp_err) exp_lat = 1 + ADN + TIMEOUT;
        else exp_lat = 1 + ADN + dly + 1 + N + $countones(stl);
        check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        check({nm, "_resp"}, {22'd0, er, rr, rd}, {22'd0, exp_err, 1'b0, exp_rd});
        @(negedge clk);
        check({nm, "_pulse"}, 32'(resp_valid), 32'd0);
        check({nm, "_busaddr"}, 32'(last_av), 32'({1'b0, a}));
        check({nm, "_buswdata"}, 32'(last_dv), wr ? 32'(d) : 32'd0);
        check({nm, "_buswren"}, 32'(last_wv), wr ? 32'(13'h1FFF) : 32'd0);
        check({nm, "_buslen"}, 32'(last_len), 32'(ADN + 1));
        if (wr) ref_mem[a] = d;
    endtask

    typedef struct {
        string          nm;
        bit             wr;
        logic [ADN-1:0] a;
        logic [N-1:0]   d;
        int             dly;
        logic [N-1:0]   stl;
        bit             mute;
        logic [N-1:0]   exp_rd;
        bit             exp_err;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int pulses, t0, lat;
        logic [ADN-1:0] a;
        logic [N-1:0] d, rd;
        logic er, rr;
        bit wr;

        tbl[0] = '{"wr_abc",  1'b1, 12'hABC, 8'h5A, 0,  8'h00, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{"rd_003",  1'b0, 12'h003, 8'h00, 3,  8'h00, 1'b0, 8'hA5, 1'b0};
        tbl[2] = '{"rd_abc",  1'b0, 12'hABC, 8'h00, 5,  8'h51, 1'b0, 8'h5A, 1'b0};
        tbl[3] = '{"wr_fff",  1'b1, 12'hFFF, 8'hFF, 0,  8'h00, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{"rd_fff",  1'b0, 12'hFFF, 8'h00, 0,  8'h00, 1'b0, 8'hFF, 1'b0};
        tbl[5] = '{"rd_tmo",  1'b0, 12'h003, 8'h00, 0,  8'h00, 1'b1, 8'h00, 1'b1};
        tbl[6] = '{"rd_edge", 1'b0, 12'h003, 8'h00, 54, 8'h00, 1'b0, 8'hA5, 1'b0};
        tbl[7] = '{"rd_late", 1'b0, 12'h003, 8'h00, 60, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[8] = '{"wr_000",  1'b1, 12'h000, 8'hC3, 0,  8'h00, 1'b0, 8'h00, 1'b0};
        tbl[9] = '{"rd_000",  1'b0, 12'h000, 8'h00, 0,  8'hFF, 1'b0, 8'hC3, 1'b0};

        reset = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; bus_ready = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            smem[i] = '0;
            ref_mem[i] = '0;
        end
        smem[3] = 8'hA5; ref_mem[3] = 8'hA5;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'(outs_s), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++)
            run(tbl[i].nm, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].dly, tbl[i].stl,
                tbl[i].mute, tbl[i].exp_rd, tbl[i].exp_err);

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 12'($urandom) & 12'h0F3;
            d  = 8'($urandom);
            run("rand", wr, a, d, $urandom_range(0, 20), 8'($urandom) & 8'($urandom),
                1'b0, wr ? 8'h00 : ref_mem[a], 1'b0);
        end

        // bus_ready low holds off a pending request; raising it lets the transfer start.
        wait_idle();
        bus_ready = 1'b0;
        @(negedge clk);
        req = 1'b1; req_wr = 1'b1; req_addr = 12'h123; req_wdata = 8'h77;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("busy_hold", {30'd0, req_ready, bus_valid}, 32'd0);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        check("ready_rise", {30'd0, req_ready, bus_valid}, 32'd2);
        @(negedge clk);
        check("ready_start", 32'(bus_valid), 32'd1);
        req = 1'b0;
        wait_resp(1, lat, rd, er, rr);
        check("ready_lat", 32'(lat), 32'(1 + ADN + 2));
        ref_mem[12'h123] = 8'h77;
        run("rd_123", 1'b0, 12'h123, 8'h00, 2, 8'h00, 1'b0, ref_mem[12'h123], 1'b0);

        // A request pulse during ADDR of a write is ignored.
        wait_idle();
        t0 = txn_cnt;
        req = 1'b1; req_wr = 1'b1; req_addr = 12'h200; req_wdata = 8'h11;
        @(negedge clk);
        req = 1'b0;
        pulses = 0;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (k == 5) begin
                req = 1'b1; req_addr = 12'h300; req_wdata = 8'h99;
            end
            if (k == 6) req = 1'b0;
            if (resp_valid) pulses++;
        end
        check("poke_pulses", 32'(pulses), 32'd1);
        check("poke_txns", 32'(txn_cnt - t0), 32'd1);
        ref_mem[12'h200] = 8'h11;
        run("rd_200", 1'b0, 12'h200, 8'h00, 0, 8'h00, 1'b0, ref_mem[12'h200], 1'b0);
        run("rd_300", 1'b0, 12'h300, 8'h00, 0, 8'h00, 1'b0, ref_mem[12'h300], 1'b0);

        // Reset in ADDR cycle 5 aborts the write with no response.
        wait_idle();
        req = 1'b1; req_wr = 1'b1; req_addr = 12'h400; req_wdata = 8'hEE;
        @(negedge clk);
        req = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_outs", 32'(outs_s), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        t0 = txn_cnt;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("rst_noresp", 32'(pulses), 32'd0);
        check("rst_notxn", 32'(txn_cnt - t0), 32'd0);
        run("rd_400", 1'b0, 12'h400, 8'h00, 1, 8'h24, 1'b0, ref_mem[12'h400], 1'b0);

        check("burst_zero", 32'(burst_seen), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
